// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative 32-bit multiply/divide unit with HI/LO registers.
//
// Multiply is shift-add on operand magnitudes, divide is restoring division
// on magnitudes; both retire one bit per ITER cycle. Signs are applied in FIX.
// Latency from an accepted start to the done pulse is 34 cycles for every op.
//
// Ports:
//   clk    in   1   clock, rising edge
//   reset  in   1   synchronous, active-high
//   a      in  32   multiplicand / dividend, also the mthi/mtlo source
//   b      in  32   multiplier / divisor
//   start  in   1   launch request (IDLE only)
//   op     in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   mthi   in   1   load a into HI (IDLE only)
//   mtlo   in   1   load a into LO (IDLE only)
//   hi     out 32   product upper half / remainder
//   lo     out 32   product lower half / quotient
//   busy   out  1   state is not IDLE
//   done   out  1   one-cycle pulse after an operation writes HI/LO
//
// Build option: define MULDIV_DIV_EN to include DIV/DIVU. Without it the
// divide datapath is absent and a start with op=1x is ignored.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        mthi,
    input  logic        mtlo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t      state, state_next;
    logic [4:0]  cnt;
    logic [63:0] work;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] opnd;      // multiplicand magnitude or divisor magnitude
    logic        neg_a, neg_b;
    logic        launch;
    logic        op_signed;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [63:0] prod_fix;
    logic [31:0] res_hi, res_lo;

    function automatic logic [31:0] neg32(input logic n, input logic [31:0] x);
        return n ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [63:0] neg64(input logic n, input logic [63:0] x);
        return n ? (~x + 64'd1) : x;
    endfunction

    assign op_signed = ~op[0];
    assign mag_a     = neg32(op_signed & a[31], a);
    assign mag_b     = neg32(op_signed & b[31], b);
    assign busy      = (state != IDLE);

`ifdef MULDIV_DIV_EN
    logic        is_div;
    logic        b_zero;
    logic [31:0] a_r;       // raw dividend, returned in HI on divide by zero
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic        div_ge;
    logic [63:0] div_step;

    assign launch    = start;
    assign div_shift = {work[63:32], work[31]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    assign div_ge    = ~div_diff[33];
    assign div_step  = {(div_ge ? div_diff[31:0] : div_shift[31:0]), work[30:0], div_ge};
`else
    assign launch    = start & ~op[1];
`endif

    // Shift-add step: add multiplicand when the current multiplier bit is set,
    // then shift the whole {product, multiplier} pair right by one.
    assign mul_sum  = {1'b0, work[63:32]} + (work[0] ? {1'b0, opnd} : 33'd0);
    assign mul_step = {mul_sum, work[31:1]};
    assign prod_fix = neg64(neg_a ^ neg_b, work);

    always_comb begin
        res_hi = prod_fix[63:32];
        res_lo = prod_fix[31:0];
`ifdef MULDIV_DIV_EN
        if (is_div) begin
            if (b_zero) begin
                res_hi = a_r;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                // Quotient truncates toward zero; remainder follows the dividend.
                res_hi = neg32(neg_a, work[63:32]);
                res_lo = neg32(neg_a ^ neg_b, work[31:0]);
            end
        end
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch) state_next = ITER;
            ITER:    if (cnt == 5'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 5'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == FIX);
            case (state)
                // Operand capture; moves only when no operation is launched.
                IDLE: begin
                    if (launch) begin
                        cnt   <= 5'd0;
                        neg_a <= op_signed & a[31];
                        neg_b <= op_signed & b[31];
`ifdef MULDIV_DIV_EN
                        is_div <= op[1];
                        b_zero <= (b == 32'd0);
                        a_r    <= a;
                        if (op[1]) begin
                            work <= {32'd0, mag_a};
                            opnd <= mag_b;
                        end else begin
                            work <= {32'd0, mag_b};
                            opnd <= mag_a;
                        end
`else
                        work <= {32'd0, mag_b};
                        opnd <= mag_a;
`endif
                    end else begin
                        if (mthi) hi <= a;
                        if (mtlo) lo <= a;
                    end
                end
                // One bit per cycle.
                ITER: begin
                    cnt <= cnt + 5'd1;
`ifdef MULDIV_DIV_EN
                    work <= is_div ? div_step : mul_step;
`else
                    work <= mul_step;
`endif
                end
                // Sign fix and HI/LO write.
                FIX: begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed self-checking bench for muldiv_unit.
// Divide vectors are exercised when MULDIV_DIV_EN is defined; otherwise the
// bench checks that a divide start is ignored.
module tb_muldiv_unit;
    logic        clk;
    logic        reset;
    logic [31:0] a, b;
    logic        start;
    logic [1:0]  op;
    logic        mthi, mtlo;
    logic [31:0] hi, lo;
    logic        busy, done;

    int total = 0;
    int bad   = 0;
    logic [31:0] m_hi, m_lo;   // expected HI/LO contents

    muldiv_unit dut (
        .clk  (clk),
        .reset(reset),
        .a    (a),
        .b    (b),
        .start(start),
        .op   (op),
        .mthi (mthi),
        .mtlo (mtlo),
        .hi   (hi),
        .lo   (lo),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Launch one op, scramble inputs after capture, watch cycles 1..35.
    // inj>0: assert start+mthi+mtlo in cycle inj (must be ignored).
    // mv: assert mthi+mtlo together with start (start must win).
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                         input int inj, input bit mv);
        bit busy_ok, done_early, held;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1; mthi = mv; mtlo = mv;
        @(posedge clk);
        #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0; a = ~x; b = ~y; op = ~o;
        busy_ok = 1'b1; done_early = 1'b0; held = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done !== 1'b0) done_early = 1'b1;
            if (hi !== m_hi || lo !== m_lo) held = 1'b0;
            if (k == inj) begin
                start = 1'b1; mthi = 1'b1; mtlo = 1'b1; a = 32'hDEAD_0000; op = 2'b01;
            end
            if (k == inj + 1) begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            end
        end
        chk({tag, " busy_1_33"}, {31'd0, busy_ok}, 32'd1);
        chk({tag, " no_early_done"}, {31'd0, done_early}, 32'd0);
        chk({tag, " hilo_held"}, {31'd0, held}, 32'd1);
        @(negedge clk);
        chk({tag, " done_c34"}, {31'd0, done}, 32'd1);
        chk({tag, " busy_c34"}, {31'd0, busy}, 32'd0);
        chk({tag, " hi"}, hi, ehi);
        chk({tag, " lo"}, lo, elo);
        @(negedge clk);
        chk({tag, " done_c35"}, {31'd0, done}, 32'd0);
        chk({tag, " busy_c35"}, {31'd0, busy}, 32'd0);
        m_hi = ehi;
        m_lo = elo;
    endtask

    task automatic do_move(input string tag, input bit h, input bit l, input logic [31:0] x);
        @(negedge clk);
        a = x; mthi = h; mtlo = l;
        @(posedge clk);
        #1;
        mthi = 1'b0; mtlo = 1'b0; a = 32'd0;
        if (h) m_hi = x;
        if (l) m_lo = x;
        @(negedge clk);
        chk({tag, " hi"}, hi, m_hi);
        chk({tag, " lo"}, lo, m_lo);
        chk({tag, " done"}, {31'd0, done}, 32'd0);
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        bit quiet;
        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        a = 32'd0; b = 32'd0; op = 2'b00;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        do_move("mthi", 1'b1, 1'b0, 32'h1234_5678);
        do_move("mtlo", 1'b0, 1'b1, 32'hCAFE_F00D);
        do_move("mthilo", 1'b1, 1'b1, 32'h55AA_55AA);

        do_op("mult_m3x7",   2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 1'b0);
        do_op("multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 1'b0);
        do_op("multu_shift", 2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 0, 1'b0);
        do_op("mult_minsq",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 1'b0);
        do_op("mult_m1m1",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0, 1'b0);
        do_op("mult_inj",    2'b00, 32'd5,         32'd6,         32'h0000_0000, 32'd30,        5, 1'b0);
        do_move("pre_mv", 1'b1, 1'b1, 32'h0BAD_0BAD);
        do_op("multu_mv",    2'b01, 32'd3,         32'd4,         32'h0000_0000, 32'd12,        0, 1'b1);

`ifdef MULDIV_DIV_EN
        do_op("div_m7d2",    2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1'b0);
        do_op("divu_by0",    2'b11, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 0, 1'b0);
        do_op("div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 1'b0);
        do_op("divu_100_7",  2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        0, 1'b0);
        do_op("div_7dm2",    2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 0, 1'b0);
        do_op("div_m7by0",   2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 0, 1'b0);
`else
        @(negedge clk);
        op = 2'b10; a = 32'd7; b = 32'd0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) quiet = 1'b0;
        end
        chk("nodiv ignored", {31'd0, quiet}, 32'd1);
`endif

        // Reset in cycle 10 of an operation aborts it.
        do_move("pre_rst", 1'b1, 1'b1, 32'h1111_1111);
        @(negedge clk);
        op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        quiet = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) quiet = 1'b0;
        end
        chk("abort quiet", {31'd0, quiet}, 32'd1);

        // Reset beats start and moves in the same cycle.
        do_move("pre_prio", 1'b1, 1'b1, 32'h2222_2222);
        @(negedge clk);
        reset = 1'b1; start = 1'b1; mthi = 1'b1; mtlo = 1'b1; op = 2'b01; a = 32'h3333_3333; b = 32'd1;
        @(posedge clk);
        #1;
        reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        @(negedge clk);
        chk("prio busy", {31'd0, busy}, 32'd0);
        chk("prio hi", hi, 32'd0);
        chk("prio lo", lo, 32'd0);
        @(negedge clk);
        chk("prio busy2", {31'd0, busy}, 32'd0);
        chk("prio done2", {31'd0, done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
